// File: rtl/ifm_bram_ctrl.sv
// ifm_bram_ctrl
//   Single-port arbiter/sequencer in front of the input-feature-map BRAM.
//   A loader writes single 16-byte words; a reader launches strided bursts
//   (base + i*stride, i = 0..len-1) and gets the words back in issue order
//   with a fixed BRAM read latency of one cycle.
//
//   Optional feature macro: IFM_CTRL_RD_PRIORITY_EN
//     undefined : a pending wr_req always wins the BRAM; the burst stalls.
//     defined   : bursts in READ win; writes wait until the burst leaves READ.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_req/addr/data     loader write request; wr_ack = granted this cycle
//   rd_start             one-cycle pulse, accepted only while idle
//   rd_base/stride/len   burst byte base, byte stride, word count (0..256)
//   rd_busy              high from the cycle after acceptance through rd_done
//   rd_data_valid/data   returned words, one cycle after each issue
//   rd_done              one-cycle pulse with the last word (or alone for len 0)
//   ifm_address, data_in, write_en, ifm_address_valid  BRAM request side
//   ifm_out              BRAM read data (valid one cycle after a read request)
module ifm_bram_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_req,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ack,
  input  logic                     rd_start,
  input  logic [ADDRESS_WIDTH-1:0] rd_base,
  input  logic [15:0]              rd_stride,
  input  logic [8:0]               rd_len,
  output logic                     rd_busy,
  output logic                     rd_data_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_done,
  output logic [ADDRESS_WIDTH-1:0] ifm_address,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic                     write_en,
  output logic                     ifm_address_valid,
  input  logic [DATA_WIDTH-1:0]    ifm_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // BRAM read latency. DRAIN lasts exactly one cycle, which is what lines
  // rd_done up with the final returned word; changing this requires a
  // longer drain as well.
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic                     vld;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } bram_req_t;

  logic [1:0]               state;
  logic [ADDRESS_WIDTH-1:0] addr_q;    // base + idx*stride, kept incrementally
  logic [15:0]              stride_q;
  logic [8:0]               len_q;
  logic [8:0]               idx_q;
  logic [RD_LAT:1]          vld_pipe;

  logic                     rd_phase;
  logic                     grant;
  logic                     issue;
  logic                     last_issue;
  logic [8:0]               idx_nxt;
  logic [ADDRESS_WIDTH-1:0] stride_ext;
  bram_req_t                req;

  assign rd_phase = (state == READ);

  // The write grant is purely combinational from wr_req, so it is gated
  // with rst_n to keep wr_ack/write_en quiet while reset is held.
`ifdef IFM_CTRL_RD_PRIORITY_EN
  assign grant = rst_n & wr_req & ~rd_phase;
`else
  assign grant = rst_n & wr_req;
`endif

  // One BRAM access per cycle: a read issues only when no write is granted.
  assign issue      = rd_phase & ~grant;
  assign idx_nxt    = idx_q + 9'd1;
  assign last_issue = issue & (idx_nxt == len_q);

  // Running address replaces base + idx*stride; both wrap mod 2^ADDRESS_WIDTH.
  assign stride_ext = ADDRESS_WIDTH'(stride_q);

  always_comb begin
    req      = '0;
    req.addr = addr_q;
    req.data = wr_data;
    if (grant) begin
      req.vld  = 1'b1;
      req.we   = 1'b1;
      req.addr = wr_addr;
    end else if (issue) begin
      req.vld  = 1'b1;
    end
  end

  assign ifm_address_valid = req.vld;
  assign write_en          = req.we;
  assign ifm_address       = req.addr;
  assign data_in           = req.data;
  assign wr_ack            = grant;

  assign rd_busy       = (state != IDLE);
  assign rd_done       = (state == DRAIN);
  assign rd_data_valid = vld_pipe[RD_LAT];
  // Zeroed when not valid so rd_data reads 0 in reset and between words.
  assign rd_data       = vld_pipe[RD_LAT] ? ifm_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= RD_LAT'({vld_pipe, issue});
      case (state)
        IDLE: begin
          if (rd_start) begin
            addr_q   <= rd_base;
            stride_q <= rd_stride;
            len_q    <= rd_len;
            idx_q    <= '0;
            state    <= (rd_len == 9'd0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue) begin
            idx_q  <= idx_nxt;
            addr_q <= addr_q + stride_ext;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
